l2_fill_writer: RTL and testbench

L2_FILL_WRITER -- requirements
Module: l2_fill_writer

---
 rtl/l2_fill_writer.sv | 161 ++++++++++++++++
 tb/tb_l2_fill_writer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_fill_writer.sv
// ============================================================================
// Module  : l2_fill_writer
// Purpose : Picks the L2 way for a fill or update, tells the victim path about
//           evictions and issues a one-cycle write to the tag/state array.
//           Optional macro L2_EVICT_NOTIFY_EN adds the EVICT handshake state.
// Revision: 1.0
// ============================================================================
`default_nettype none

module l2_fill_writer #(
  parameter  int WAYS       = 8,
  parameter  int SETS       = 256,
  parameter  int TAG_BITS   = 15,
  parameter  int STATE_BITS = 3,
  localparam int WW         = $clog2(WAYS),
  localparam int SW         = $clog2(SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SW-1:0]         req_set,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [STATE_BITS-1:0] req_state,
  input  logic                  req_hit,
  input  logic [WW-1:0]         req_hit_way,
  input  logic                  req_empty_found,
  input  logic [WW-1:0]         req_empty_way,
  output logic                  wr_en,
  output logic [SW-1:0]         wr_set,
  output logic [WW-1:0]         wr_way,
  output logic [TAG_BITS-1:0]   wr_tag,
  output logic [STATE_BITS-1:0] wr_state,
  output logic                  evict_valid,
  input  logic                  evict_ready,
  output logic [SW-1:0]         evict_set,
  output logic [WW-1:0]         evict_way,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EVICT  = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           set_q;
  logic [TAG_BITS-1:0]     tag_q;
  logic [STATE_BITS-1:0]   st_q;
  logic                    hit_q;
  logic [WW-1:0]           hit_way_q;
  logic                    empty_q;
  logic [WW-1:0]           empty_way_q;
  logic [WW-1:0]           way_q, way_d;
  logic                    victim_q, victim_d;
  logic [WW-1:0]           evict_ptr_q [SETS];

  logic accept;
  assign accept = req_valid && (state_q == IDLE);

  // Hit beats empty way; only a full set falls back to the round-robin victim.
  always_comb begin
    way_d    = evict_ptr_q[set_q];
    victim_d = 1'b1;
    if (hit_q) begin
      way_d    = hit_way_q;
      victim_d = 1'b0;
    end else if (empty_q) begin
      way_d    = empty_way_q;
      victim_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = SELECT;
`ifdef L2_EVICT_NOTIFY_EN
      SELECT:  state_d = victim_d ? EVICT : WRITE;
      EVICT:   if (evict_ready) state_d = WRITE;
`else
      SELECT:  state_d = WRITE;
      EVICT:   state_d = WRITE;
`endif
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q       <= '0;
      tag_q       <= '0;
      st_q        <= '0;
      hit_q       <= 1'b0;
      hit_way_q   <= '0;
      empty_q     <= 1'b0;
      empty_way_q <= '0;
      way_q       <= '0;
      victim_q    <= 1'b0;
    end else begin
      if (accept) begin
        set_q       <= req_set;
        tag_q       <= req_tag;
        st_q        <= req_state;
        hit_q       <= req_hit;
        hit_way_q   <= req_hit_way;
        empty_q     <= req_empty_found;
        empty_way_q <= req_empty_way;
      end
      if (state_q == SELECT) begin
        way_q    <= way_d;
        victim_q <= victim_d;
      end
    end
  end

  // WW-bit add wraps WAYS-1 back to 0 because WAYS is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        evict_ptr_q[s] <= '0;
      end
    end else if ((state_q == WRITE) && victim_q) begin
      evict_ptr_q[set_q] <= evict_ptr_q[set_q] + 1'b1;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign wr_en     = (state_q == WRITE);
  assign done      = (state_q == WRITE);
  assign wr_set    = set_q;
  assign wr_way    = way_q;
  assign wr_tag    = tag_q;
  assign wr_state  = st_q;

`ifdef L2_EVICT_NOTIFY_EN
  assign evict_valid = (state_q == EVICT);
  assign evict_set   = set_q;
  assign evict_way   = way_q;
`else
  logic unused_evict_ready;
  assign unused_evict_ready = evict_ready;
  assign evict_valid = 1'b0;
  assign evict_set   = '0;
  assign evict_way   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_fill_writer.sv
// ============================================================================
// Module  : tb_l2_fill_writer
// Purpose : Directed self-checking bench for l2_fill_writer (either build of
//           L2_EVICT_NOTIFY_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_l2_fill_writer;

  localparam int WAYS = 8, SETS = 256, TAG_BITS = 15, STATE_BITS = 3;
  localparam int WW = 3, SW = 8;
`ifdef L2_EVICT_NOTIFY_EN
  localparam int NOTIFY = 1;
`else
  localparam int NOTIFY = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic [SW-1:0]         req_set;
  logic [TAG_BITS-1:0]   req_tag;
  logic [STATE_BITS-1:0] req_state;
  logic                  req_hit;
  logic [WW-1:0]         req_hit_way;
  logic                  req_empty_found;
  logic [WW-1:0]         req_empty_way;
  logic                  wr_en;
  logic [SW-1:0]         wr_set;
  logic [WW-1:0]         wr_way;
  logic [TAG_BITS-1:0]   wr_tag;
  logic [STATE_BITS-1:0] wr_state;
  logic                  evict_valid;
  logic                  evict_ready;
  logic [SW-1:0]         evict_set;
  logic [WW-1:0]         evict_way;
  logic                  done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  l2_fill_writer #(
    .WAYS(WAYS), .SETS(SETS), .TAG_BITS(TAG_BITS), .STATE_BITS(STATE_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_tag(req_tag), .req_state(req_state),
    .req_hit(req_hit), .req_hit_way(req_hit_way),
    .req_empty_found(req_empty_found), .req_empty_way(req_empty_way),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way),
    .wr_tag(wr_tag), .wr_state(wr_state),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_set(evict_set), .evict_way(evict_way),
    .done(done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int set, input int tag, input int st,
                           input bit hit, input int hway, input bit emp, input int eway);
    @(negedge clk);
    req_valid       = 1'b1;
    req_set         = SW'(set);
    req_tag         = TAG_BITS'(tag);
    req_state       = STATE_BITS'(st);
    req_hit         = hit;
    req_hit_way     = WW'(hway);
    req_empty_found = emp;
    req_empty_way   = WW'(eway);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // One request; cycle k is the k-th negedge after the acceptance edge.
  task automatic do_req(input int set, input int tag, input int st,
                        input bit hit, input int hway, input bit emp, input int eway,
                        input int stall,
                        output int wcyc, output int wway, output int wset,
                        output int wtag, output int wst, output int wdone,
                        output int evc, output int evway, output int evbad,
                        output int rdybad);
    wcyc = -1; wway = -1; wset = -1; wtag = -1; wst = -1; wdone = 0;
    evc = 0; evway = -1; evbad = 0; rdybad = 0;
    drive_req(set, tag, st, hit, hway, emp, eway);
    for (int k = 1; k <= 30 && wcyc < 0; k++) begin
      @(negedge clk);
      if (evict_valid) begin
        evc++;
        if (evc == 1) evway = int'(evict_way);
        else if (int'(evict_way) != evway || evict_set != SW'(set)) evbad++;
        evict_ready = (evc > stall);
      end
      if (wr_en) begin
        wcyc  = k;
        wway  = int'(wr_way);
        wset  = int'(wr_set);
        wtag  = int'(wr_tag);
        wst   = int'(wr_state);
        wdone = int'(done);
        evict_ready = 1'b0;
      end else if (req_ready) begin
        rdybad++;
      end
    end
    @(negedge clk);
    if (!req_ready) rdybad++;
  endtask

  int wcyc, wway, wset, wtag, wst, wdone, evc, evway, evbad, rdybad, cnt;
  int exp_ways [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_set = '0; req_tag = '0; req_state = '0;
    req_hit = 1'b0; req_hit_way = '0; req_empty_found = 1'b0; req_empty_way = '0;
    evict_ready = 1'b0;
    #22;
    check_val("rst_ready", req_ready, 1);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_done", done, 0);
    check_val("rst_evict_valid", evict_valid, 0);
    check_val("rst_wr_data", {wr_set, wr_way, wr_tag, wr_state}, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", req_ready, 1);

    // Hit fill, set 5 way 3
    do_req(5, 'h1234, 2, 1, 3, 0, 0, 0, wcyc, wway, wset, wtag, wst, wdone, evc, evway, evbad, rdybad);
    check_val("hit_cycle", wcyc, 2);
    check_val("hit_set", wset, 5);
    check_val("hit_way", wway, 3);
    check_val("hit_tag", wtag, 'h1234);
    check_val("hit_state", wst, 2);
    check_val("hit_done", wdone, 1);
    check_val("hit_evict", evc, 0);
    check_val("hit_ready", rdybad, 0);
    // Pointer of set 5 untouched by the hit -> first victim takes way 0
    do_req(5, 'h0042, 1, 0, 0, 0, 0, 0, wcyc, wway, wset, wtag, wst, wdone, evc, evway, evbad, rdybad);
    check_val("set5_victim_way", wway, 0);
    check_val("set5_victim_cycle", wcyc, 2 + NOTIFY);
    check_val("set5_victim_evc", evc, NOTIFY);

    // Empty way 6
    do_req(7, 'h7fff, 5, 0, 2, 1, 6, 0, wcyc, wway, wset, wtag, wst, wdone, evc, evway, evbad, rdybad);
    check_val("empty_way", wway, 6);
    check_val("empty_cycle", wcyc, 2);
    check_val("empty_evict", evc, 0);
    check_val("empty_tag", wtag, 'h7fff);
    // Hit beats empty
    do_req(7, 'h0011, 3, 1, 1, 1, 4, 0, wcyc, wway, wset, wtag, wst, wdone, evc, evway, evbad, rdybad);
    check_val("prio_way", wway, 1);

    // Round robin over set 9
    for (int i = 0; i < 9; i++) begin
      do_req(9, 'h100 + i, 1, 0, 0, 0, 0, 0, wcyc, wway, wset, wtag, wst, wdone, evc, evway, evbad, rdybad);
      check_val($sformatf("rr_way_%0d", i), wway, exp_ways[i]);
      check_val($sformatf("rr_cycle_%0d", i), wcyc, 2 + NOTIFY);
      check_val($sformatf("rr_ready_%0d", i), rdybad, 0);
      if (NOTIFY != 0) check_val($sformatf("rr_evway_%0d", i), evway, exp_ways[i]);
    end

`ifdef L2_EVICT_NOTIFY_EN
    // Four cycles of back-pressure on evict_ready
    do_req(20, 'h0abc, 4, 0, 0, 0, 0, 4, wcyc, wway, wset, wtag, wst, wdone, evc, evway, evbad, rdybad);
    check_val("stall_evc", evc, 5);
    check_val("stall_evbad", evbad, 0);
    check_val("stall_cycle", wcyc, 7);
    check_val("stall_way", wway, 0);
    check_val("stall_ready", rdybad, 0);
    // Reset in the middle of EVICT (set 20 pointer is now 1)
    drive_req(20, 'h0def, 4, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_val("mid_evict_valid", evict_valid, 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_evict_valid", evict_valid, 0);
    check_val("mid_rst_wr_en", wr_en, 0);
    check_val("mid_rst_ready", req_ready, 1);
`else
    // Reset in the middle of WRITE
    drive_req(9, 'h0def, 4, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_val("mid_write_wr_en", wr_en, 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_wr_en", wr_en, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_wr_data", {wr_set, wr_way, wr_tag, wr_state}, 0);
`endif
    evict_ready = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_val("after_rst_ready", req_ready, 1);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (wr_en) cnt++;
    end
    evict_ready = 1'b0;
    check_val("after_rst_no_write", cnt, 0);
    do_req(20 - 11 * (1 - NOTIFY), 'h0321, 2, 0, 0, 0, 0, 0,
           wcyc, wway, wset, wtag, wst, wdone, evc, evway, evbad, rdybad);
    check_val("after_rst_victim_way", wway, 0);
    check_val("after_rst_victim_cycle", wcyc, 2 + NOTIFY);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
